// File: rtl/onchip_mem_arbiter_pkg.sv
// rtl/onchip_mem_arbiter_pkg.sv - shared types and defaults for the on-chip RAM arbiter
package onchip_mem_arbiter_pkg;

   typedef enum logic {
      M_IFETCH = 1'b0,
      M_DATA   = 1'b1
   } master_id_e;

   localparam int NUM_MASTERS    = 2;
   localparam int DEFAULT_ADDR_W = 13;
   localparam int DEFAULT_DATA_W = 64;

endpackage

// File: rtl/onchip_mem_arbiter_rr.sv
// rtl/onchip_mem_arbiter_rr.sv - two-way round-robin grant with last_grant register
module rr_arbiter2
   import onchip_mem_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   master_id_e last_grant_q;
   master_id_e last_grant_d;

   always_comb begin
      grant        = 2'b00;
      last_grant_d = last_grant_q;
      if (!reset) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // contention: the master that did not win last time goes first
            2'b11:   grant = (last_grant_q == M_DATA) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
      if (grant[0]) begin
         last_grant_d = M_IFETCH;
      end else if (grant[1]) begin
         last_grant_d = M_DATA;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= M_DATA;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - shares one single-port 1-cycle-latency RAM between
// an instruction-fetch master and a data master
module onchip_mem_arbiter
   import onchip_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,

   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,

   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
);

   logic [1:0]  req;
   logic [1:0]  grant;
   logic        rd_accept;
   logic        rd_valid_q;
   logic        rd_valid_d;
   master_id_e  rd_owner_q;
   master_id_e  rd_owner_d;

   rr_arbiter2 u_rr (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .grant (grant)
   );

   always_comb begin
      req            = {m1_read | m1_write, m0_read | m0_write};
      m0_waitrequest = req[0] & ~grant[0];
      m1_waitrequest = req[1] & ~grant[1];

      mem_address    = grant[1] ? m1_address    : m0_address;
      mem_byteenable = grant[1] ? m1_byteenable : m0_byteenable;
      mem_writedata  = grant[1] ? m1_writedata  : m0_writedata;
      mem_chipselect = |grant;
      mem_write      = (grant[0] & m0_write) | (grant[1] & m1_write);
      mem_clken      = 1'b1;

      // read+write together is a write, so it never books a read response
      rd_accept  = (grant[0] & m0_read & ~m0_write) | (grant[1] & m1_read & ~m1_write);
      rd_valid_d = rd_accept & ~reset;
      rd_owner_d = grant[1] ? M_DATA : M_IFETCH;

      m0_readdata      = mem_readdata;
      m1_readdata      = mem_readdata;
      m0_readdatavalid = rd_valid_q & ~reset & (rd_owner_q == M_IFETCH);
      m1_readdatavalid = rd_valid_q & ~reset & (rd_owner_q == M_DATA);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_valid_d;
      end
      rd_owner_q <= rd_owner_d;
   end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - scoreboard bench for onchip_mem_arbiter
module tb_onchip_mem_arbiter;

   logic         clk;
   logic         reset;
   logic [12:0]  m0_address, m1_address;
   logic         m0_read, m0_write, m1_read, m1_write;
   logic [7:0]   m0_byteenable, m1_byteenable;
   logic [63:0]  m0_writedata, m1_writedata;
   logic         m0_waitrequest, m1_waitrequest;
   logic [63:0]  m0_readdata, m1_readdata;
   logic         m0_readdatavalid, m1_readdatavalid;
   logic [12:0]  mem_address;
   logic [7:0]   mem_byteenable;
   logic [63:0]  mem_writedata;
   logic         mem_chipselect, mem_write, mem_clken;
   logic [63:0]  mem_readdata;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int          owner;
      logic [63:0] data;
   } exp_t;
   exp_t exp_q[$];

   logic [63:0] ram    [0:8191];
   logic [63:0] shadow [0:8191];

   onchip_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] init_word(input logic [12:0] a);
      return {16'hA5A5, 3'b000, a, 16'h5A5A, 3'b000, a};
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                         input logic [7:0] be);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   // single-port RAM, 1-cycle read latency, read-before-write
   always @(posedge clk) begin
      if (mem_chipselect && mem_clken) begin
         mem_readdata <= ram[mem_address];
         if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int owner, input logic [12:0] a);
      exp_t e;
      e.owner = owner;
      e.data  = shadow[a];
      exp_q.push_back(e);
   endtask

   task automatic idle_all();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
      m0_byteenable = 8'hFF; m1_byteenable = 8'hFF;
      m0_writedata = '0; m1_writedata = '0;
      m0_address = '0; m1_address = '0;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      idle_all();
      reset = 1;
      repeat (n) @(negedge clk);
      reset = 0;
   endtask

   // monitor: pops an expectation whenever a readdatavalid appears
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (m0_readdatavalid && m1_readdatavalid)
            chk("both_valid", 1, 0);
         else if (m0_readdatavalid || m1_readdatavalid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", {62'd0, m1_readdatavalid, m0_readdatavalid}, 0);
            end else begin
               e = exp_q.pop_front();
               chk("rd_owner", m1_readdatavalid ? 1 : 0, e.owner);
               chk("rd_data", m1_readdatavalid ? m1_readdata : m0_readdata, e.data);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int c0, c1;
      for (int i = 0; i < 8192; i++) begin
         ram[i]    = init_word(13'(i));
         shadow[i] = init_word(13'(i));
      end
      idle_all();
      reset = 1;

      // requests held during reset see waitrequest and no RAM activity
      @(negedge clk);
      m0_read = 1; m1_write = 1;
      #1;
      chk("rst_wait0", m0_waitrequest, 1);
      chk("rst_wait1", m1_waitrequest, 1);
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_wr", mem_write, 0);
      chk("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
      chk("clken", mem_clken, 1);
      do_reset(2);

      // lone m0 read of 0x0010
      @(negedge clk);
      m0_read = 1; m0_address = 13'h0010;
      #1;
      chk("single_wait0", m0_waitrequest, 0);
      chk("single_wait1_idle", m1_waitrequest, 0);
      chk("single_addr", mem_address, 13'h0010);
      chk("single_cs", mem_chipselect, 1);
      push_exp(0, 13'h0010);
      @(negedge clk);
      idle_all();
      repeat (2) @(negedge clk);

      // contention from reset alternates m0, m1, m0, ...
      do_reset(2);
      g = 0; c0 = 0; c1 = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         m0_read = 1; m1_read = 1;
         m0_address = 13'h0100 + 13'(c0);
         m1_address = 13'h0200 + 13'(c1);
         #1;
         chk("rr_wait0", m0_waitrequest, (g == 0) ? 0 : 1);
         chk("rr_wait1", m1_waitrequest, (g == 1) ? 0 : 1);
         if (g == 0) begin push_exp(0, m0_address); c0++; end
         else        begin push_exp(1, m1_address); c1++; end
         g ^= 1;
      end
      @(negedge clk);
      idle_all();
      repeat (2) @(negedge clk);

      // partial write then read-back at the top address
      m1_write = 1; m1_address = 13'h1FFF;
      m1_writedata = 64'hDEADBEEF_CAFEF00D; m1_byteenable = 8'h0F;
      #1;
      chk("wr_mem_write", mem_write, 1);
      chk("wr_wait1", m1_waitrequest, 0);
      shadow[13'h1FFF] = 64'hA5A51FFF_CAFEF00D;
      @(negedge clk);
      idle_all();
      m0_read = 1; m0_address = 13'h1FFF;
      #1;
      chk("be_rd_write_low", mem_write, 0);
      push_exp(0, 13'h1FFF);
      @(negedge clk);
      idle_all();

      // read at T then write same address at T+1 returns old data
      @(negedge clk);
      m0_read = 1; m0_address = 13'h0030;
      #1;
      push_exp(0, 13'h0030);
      @(negedge clk);
      idle_all();
      m1_write = 1; m1_address = 13'h0030; m1_writedata = 64'h1111_2222_3333_4444;
      #1;
      chk("raw_wr", mem_write, 1);
      shadow[13'h0030] = 64'h1111_2222_3333_4444;
      @(negedge clk);
      idle_all();
      m1_read = 1; m1_address = 13'h0030;
      #1;
      push_exp(1, 13'h0030);
      @(negedge clk);
      idle_all();

      // read+write together behaves as a write with no response
      @(negedge clk);
      m1_read = 1; m1_write = 1; m1_address = 13'h0020;
      m1_writedata = 64'h0123_4567_89AB_CDEF;
      #1;
      chk("rw_mem_write", mem_write, 1);
      shadow[13'h0020] = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      idle_all();
      @(negedge clk);
      m1_read = 1; m1_address = 13'h0020;
      #1;
      push_exp(1, 13'h0020);
      @(negedge clk);
      idle_all();

      // read in flight when reset hits is dropped; m0 wins first contention
      @(negedge clk);
      m0_read = 1; m0_address = 13'h0050;
      #1;
      chk("pre_rst_wait0", m0_waitrequest, 0);
      @(negedge clk);
      idle_all();
      reset = 1;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      m0_read = 1; m1_read = 1; m0_address = 13'h0060; m1_address = 13'h0070;
      #1;
      chk("post_rst_wait0", m0_waitrequest, 0);
      chk("post_rst_wait1", m1_waitrequest, 1);
      push_exp(0, 13'h0060);
      @(negedge clk);
      m0_read = 0;
      #1;
      chk("post_rst_wait1b", m1_waitrequest, 0);
      push_exp(1, 13'h0070);
      @(negedge clk);
      idle_all();

      // eight back-to-back m1 reads, no stalls
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         m1_read = 1; m1_address = 13'h0040 + 13'(i);
         #1;
         chk("b2b_wait1", m1_waitrequest, 0);
         push_exp(1, m1_address);
      end
      @(negedge clk);
      idle_all();
      repeat (4) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, word-address width of the shared on-chip RAM.
REQ-002 SHALL have parameter DATA_W, default 64, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 mN_address  in  ADDR_W  master N word address (N = 0 instruction fetch, N = 1 data).
REQ-006 mN_read / mN_write  in  1 each  master N read or write request, held until accepted.
REQ-007 mN_byteenable  in  DATA_W/8  master N byte lanes; mN_writedata  in  DATA_W  master N write data.
REQ-008 mN_waitrequest  out  1  request not accepted this cycle.
REQ-009 mN_readdata  out  DATA_W  read data; mN_readdatavalid  out  1  readdata valid this cycle.
REQ-010 mem_address  out  ADDR_W; mem_byteenable  out  DATA_W/8; mem_writedata  out  DATA_W.
REQ-011 mem_chipselect  out  1; mem_write  out  1; mem_clken  out  1; mem_readdata  in  DATA_W.

Function
REQ-012 A request is mN_read | mN_write; it is accepted in the cycle its grant is asserted.
REQ-013 Grant SHALL be combinational from current requests and last_grant register; one master granted per cycle max.
REQ-014 Single requester SHALL be granted immediately; both requesting: grant the master NOT in last_grant (round-robin).
REQ-015 last_grant SHALL update to the granted master at each accepted request; unchanged when idle.
REQ-016 mN_waitrequest SHALL equal request_N & ~grant_N; SHALL be 0 when master N is not requesting.
REQ-017 Granted master's address, byteenable, writedata SHALL be muxed to mem_* the same cycle; mem_chipselect = 1 on any grant, 0 otherwise.
REQ-018 mem_write SHALL be 1 only when granted master asserts write; write completes in the accept cycle, no response.
REQ-019 mN_read with mN_write both asserted SHALL be treated as a write; read ignored.
REQ-020 RAM read latency is 1 cycle: accepted read at cycle T SHALL produce mN_readdatavalid=1 for the owner only at T+1, with mN_readdata = mem_readdata.
REQ-021 Pending-read tracker (valid bit + owner id) SHALL be written every cycle, allowing back-to-back reads from either master with no bubble.
REQ-022 mN_readdata SHALL be driven from mem_readdata for both masters; only readdatavalid is qualified by owner.
REQ-023 Read at T followed by write at T+1 to same address SHALL return pre-write data at T+1.
REQ-024 mem_clken SHALL be constant 1.
REQ-025 Throughput: one accepted transfer per cycle sustained; each master gets >= 1 of every 2 grants under contention.

Reset
REQ-026 While reset = 1: all grants 0, mN_waitrequest = request_N, mem_chipselect = 0, mem_write = 0, readdatavalid 0.
REQ-027 Reset SHALL set last_grant = 1 (master 0 wins first contention) and clear the pending-read valid bit.
REQ-028 A read accepted in the cycle before reset asserts SHALL NOT produce readdatavalid after reset.

Structure
REQ-029 Shared package SHALL hold master-id typedef (M_IFETCH=0, M_DATA=1), NUM_MASTERS=2, default ADDR_W/DATA_W.
REQ-030 Sub-module rr_arbiter2 (2-way round-robin grant + last_grant register) SHALL be instantiated; datapath mux and read tracker in top.

Verification
REQ-031 Reset, then m0 read 0x0010 alone -> m0_waitrequest=0 at T, m0_readdatavalid=1 at T+1 with RAM word 0x0010, m1_readdatavalid=0.
REQ-032 m0 and m1 both read continuously from reset -> grants alternate m0,m1,m0,...; waitrequest on non-granted master; valids follow owners at +1.
REQ-033 m1 write 0x1FFF data 0xDEADBEEF_CAFEF00D byteenable 0x0F, then m0 read 0x1FFF -> readdata low 32 bits 0xCAFEF00D, upper bytes unchanged.
REQ-034 m1 read and write same cycle to 0x0020 -> mem_write=1, no m1_readdatavalid at T+1.
REQ-035 m0 read accepted at T, reset at T+1 -> no readdatavalid on either master; first post-reset contention granted to m0.
REQ-036 m0 idle, m1 issues 8 back-to-back reads -> 8 consecutive m1_readdatavalid pulses, zero waitrequest cycles.
